// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit
// Shift-add multiply and restoring divide on magnitudes; b==0 and signed overflow bypass the iteration.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       rd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       result_rd,
  output logic             reg_write
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [4:0]         rd_q, rd_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [4:0]         result_rd_q, result_rd_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   special_val;
  logic [WIDTH:0]     mul_sum, div_top, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_step, prod;
  logic [WIDTH-1:0]   quot, rem, final_val;

  // Operand decode for the request presented in IDLE
  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        sign_a = operand_a[WIDTH-1];
        sign_b = operand_b[WIDTH-1];
      end
      3'b010: sign_a = operand_a[WIDTH-1];
      default: ;
    endcase
    a_mag = sign_a ? -operand_a : operand_a;
    b_mag = sign_b ? -operand_b : operand_b;
    div_zero = funct3[2] && (operand_b == '0);
    div_ovf  = funct3[2] && !funct3[0] && (operand_a == MIN_NEG) && (operand_b == '1);
    if (div_zero) special_val = funct3[1] ? operand_a : '1;
    else          special_val = funct3[1] ? '0 : MIN_NEG;
  end

  // One iteration: multiply adds into the high half then shifts right;
  // divide shifts the remainder/quotient pair left and trial-subtracts.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
    div_top  = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge   = div_top >= {1'b0, b_q};
    div_diff = div_top - {1'b0, b_q};
    if (op_q[2]) acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_top[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    else         acc_step = {mul_sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    prod = neg_q ? -acc_step : acc_step;
    quot = acc_step[WIDTH-1:0];
    rem  = acc_step[2*WIDTH-1:WIDTH];
    case (op_q)
      3'b000:  final_val = prod[WIDTH-1:0];
      3'b100:  final_val = neg_q ? -quot : quot;
      3'b101:  final_val = quot;
      3'b110:  final_val = neg_q ? -rem : rem;
      3'b111:  final_val = rem;
      default: final_val = prod[2*WIDTH-1:WIDTH];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    op_d        = op_q;
    b_d         = b_q;
    acc_d       = acc_q;
    neg_d       = neg_q;
    rd_d        = rd_q;
    result_d    = result_q;
    result_rd_d = result_rd_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = funct3;
          b_d     = b_mag;
          acc_d   = {{WIDTH{1'b0}}, a_mag};
          neg_d   = (funct3 == 3'b110) ? sign_a : (sign_a ^ sign_b);
          rd_d    = rd;
          count_d = '0;
          if (div_zero || div_ovf) begin
            result_d    = special_val;
            result_rd_d = rd;
            state_d     = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d   = acc_step;
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          result_d    = final_val;
          result_rd_d = rd_q;
          state_d     = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      op_q        <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      rd_q        <= '0;
      result_q    <= '0;
      result_rd_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      op_q        <= op_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      neg_q       <= neg_d;
      rd_q        <= rd_d;
      result_q    <= result_d;
      result_rd_q <= result_rd_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign reg_write = done && (result_rd_q != 5'd0);
  assign result    = result_q;
  assign result_rd = result_rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed-vector bench for muldiv_unit
// Hand-computed RV32M results, latency, write strobe, start-while-busy and mid-op reset.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  result_rd;
  logic        reg_write;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .funct3    (funct3),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .rd        (rd),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_rd (result_rd),
    .reg_write (reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Launch one op, optionally hammer start with junk while busy, then check
  // latency, outputs at done and the return to idle.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp,
                        input int lat, input bit hammer);
    int n;
    @(negedge clk);
    start = 1'b1; funct3 = f; operand_a = a; operand_b = b; rd = r;
    @(posedge clk); #1;
    start = hammer;
    n = 0;
    check({tag, "_busy1"}, {31'd0, busy}, 32'd1);
    while (done !== 1'b1 && n < 100) begin
      if (hammer) begin
        funct3    = 3'(n);
        operand_a = 32'(n * 13 + 1);
        operand_b = 32'(n + 3);
        rd        = 5'(n + 1);
      end
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n + 1), 32'(lat));
    check({tag, "_res"}, result, exp);
    check({tag, "_rd"}, {27'd0, result_rd}, {27'd0, r});
    check({tag, "_wr"}, {31'd0, reg_write}, {31'd0, (r != 5'd0)});
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_hold"}, result, exp);
  endtask

  initial begin
    int seen;
    reset = 1'b1; start = 1'b0; funct3 = '0; operand_a = '0; operand_b = '0; rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wr", {31'd0, reg_write}, 32'd0);
    check("rst_res", result, 32'd0);
    check("rst_rd", {27'd0, result_rd}, 32'd0);
    @(negedge clk); reset = 1'b0;

    run_op("mul",    3'b000, 32'd7,          32'd6,          5'd5,  32'd42,         33, 1'b0);
    run_op("mulh",   3'b001, 32'hFFFFFFFF,   32'd2,          5'd1,  32'hFFFFFFFF,   33, 1'b0);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF,   32'd2,          5'd2,  32'h00000001,   33, 1'b0);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd3,  32'hFFFFFFFF,   33, 1'b0);
    run_op("mulneg", 3'b000, 32'hFFFFFFFD,   32'd5,          5'd4,  32'hFFFFFFF1,   33, 1'b0);
    run_op("div",    3'b100, 32'hFFFFFFF9,   32'd2,          5'd6,  32'hFFFFFFFD,   33, 1'b0);
    run_op("rem",    3'b110, 32'hFFFFFFF9,   32'd2,          5'd7,  32'hFFFFFFFF,   33, 1'b0);
    run_op("divu",   3'b101, 32'd100,        32'd7,          5'd8,  32'd14,         33, 1'b0);
    run_op("remu",   3'b111, 32'd100,        32'd7,          5'd9,  32'd2,          33, 1'b0);
    run_op("divneg", 3'b100, 32'd100,        32'hFFFFFFF9,   5'd10, 32'hFFFFFFF2,   33, 1'b0);
    run_op("div0",   3'b100, 32'd5,          32'd0,          5'd11, 32'hFFFFFFFF,   1,  1'b0);
    run_op("remu0",  3'b111, 32'd5,          32'd0,          5'd12, 32'd5,          1,  1'b0);
    run_op("divovf", 3'b100, 32'h80000000,   32'hFFFFFFFF,   5'd13, 32'h80000000,   1,  1'b0);
    run_op("removf", 3'b110, 32'h80000000,   32'hFFFFFFFF,   5'd14, 32'd0,          1,  1'b0);
    run_op("hammer", 3'b101, 32'd1000,       32'd9,          5'd15, 32'd111,        33, 1'b1);
    run_op("rd0",    3'b000, 32'd2,          32'd3,          5'd0,  32'd6,          33, 1'b0);

    // Reset in the middle of a DIVU must abort it without a done pulse.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; operand_a = 32'd500; operand_b = 32'd3; rd = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_res", result, 32'd0);
    check("abort_rd", {27'd0, result_rd}, 32'd0);
    @(negedge clk); reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    check("abort_nodone", 32'(seen), 32'd0);
    run_op("mul3x3", 3'b000, 32'd3, 32'd3, 5'd21, 32'd9, 33, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
